// File: rtl/intdiv_rescollect.sv
`default_nettype none
// ============================================================================
//  Module      : intdiv_rescollect
//  Description : Request/result wrapper around an external fixed-latency
//                signed divider. Accepted requests are forwarded to the
//                divider, and their side information (tag, dividend and the
//                divide-by-zero / overflow flags) travels through a
//                LAT-deep shadow pipeline. When an entry leaves that pipeline,
//                the divider result is patched for the special cases and
//                written into a DEPTH-entry circular result FIFO.
//                Admission is credit based: a request is taken only when
//                in-flight + queued < DEPTH. A result therefore always has a
//                free FIFO slot when it arrives.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock     in   1   rising-edge clock
//    reset     in   1   synchronous, active-low reset
//    in_valid  in   1   request valid
//    in_ready  out  1   request can be accepted this cycle
//    in_x      in   N   dividend (signed)
//    in_y      in   N   divisor (signed)
//    in_tag    in   TW  request tag
//    div_x     out  N   dividend to divider (0 when idle)
//    div_y     out  N   divisor to divider (0 when idle)
//    div_z     in   N   divider quotient, LAT edges after div_x/div_y
//    div_r     in   N   divider remainder, LAT edges after div_x/div_y
//    out_valid out  1   result available
//    out_ready in   1   downstream accepts the result
//    out_z     out  N   quotient
//    out_r     out  N   remainder
//    out_tag   out  TW  tag of the result
//    out_dbz   out  1   divide-by-zero flag
//    out_ovf   out  1   overflow flag (most-negative / -1)
//    busy      out  1   any request in flight or any result queued
// ============================================================================
module intdiv_rescollect #(
    parameter int N     = 9,
    parameter int LAT   = 5,
    parameter int DEPTH = 8,
    parameter int TW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_y,
    input  logic [TW-1:0] in_tag,
    output logic [N-1:0]  div_x,
    output logic [N-1:0]  div_y,
    input  logic [N-1:0]  div_z,
    input  logic [N-1:0]  div_r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_z,
    output logic [N-1:0]  out_r,
    output logic [TW-1:0] out_tag,
    output logic          out_dbz,
    output logic          out_ovf,
    output logic          busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // FIFO pointer
    localparam int c_cw = $clog2(DEPTH + 1);                 // FIFO count
    localparam int c_iw = $clog2(LAT + 1);                   // in-flight count
    localparam int c_ow = $clog2(DEPTH + LAT + 1) + 1;       // occupancy sum

    localparam logic [N-1:0]    c_int_min  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]    c_one      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [c_pw-1:0] c_ptr_last = c_pw'(DEPTH - 1);

    // ------------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------------
    logic [c_iw-1:0] r_inflight;
    logic [c_cw-1:0] r_count;
    logic [c_ow-1:0] w_occ;
    logic            w_accept;
    logic            w_dbz;
    logic            w_ovf;

    // A result popped in this same cycle is deliberately not credited.
    assign w_occ    = c_ow'(r_inflight) + c_ow'(r_count);
    assign in_ready = (w_occ < c_ow'(DEPTH));

    // Nothing is accepted on a reset edge.
    assign w_accept = in_valid & in_ready & reset;

    assign w_dbz = (in_y == '0);
    assign w_ovf = (in_x == c_int_min) && (in_y == '1);

    // The divider never sees a zero divisor or the one overflowing pair,
    // so its behaviour in those cases does not matter. Idle cycles drive 0.
    always_comb begin
        div_x = '0;
        div_y = '0;
        if (w_accept) begin
            if (w_dbz) begin
                div_x = in_x;
                div_y = c_one;
            end else if (w_ovf) begin
                div_x = '0;
                div_y = c_one;
            end else begin
                div_x = in_x;
                div_y = in_y;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Shadow pipeline (stage LAT is index LAT-1)
    // ------------------------------------------------------------------------
    logic          r_pv   [LAT];
    logic [TW-1:0] r_ptag [LAT];
    logic [N-1:0]  r_px   [LAT];
    logic          r_pdbz [LAT];
    logic          r_povf [LAT];
    logic          w_emerge;

    // Valid bits are reset so that divider outputs belonging to discarded
    // requests are ignored after a reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                r_pv[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            for (int i = 1; i < LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
            end
        end
    end

    // Payload is qualified by the valid bits and needs no reset.
    always_ff @(posedge clock) begin
        r_ptag[0] <= in_tag;
        r_px[0]   <= in_x;
        r_pdbz[0] <= w_dbz;
        r_povf[0] <= w_ovf;
        for (int i = 1; i < LAT; i++) begin
            r_ptag[i] <= r_ptag[i-1];
            r_px[i]   <= r_px[i-1];
            r_pdbz[i] <= r_pdbz[i-1];
            r_povf[i] <= r_povf[i-1];
        end
    end

    assign w_emerge = r_pv[LAT-1];

    // ------------------------------------------------------------------------
    // Result patching for the special cases
    // ------------------------------------------------------------------------
    logic [N-1:0] w_res_z;
    logic [N-1:0] w_res_r;

    always_comb begin
        w_res_z = div_z;
        w_res_r = div_r;
        if (r_pdbz[LAT-1]) begin
            w_res_z = '1;
            w_res_r = r_px[LAT-1];
        end else if (r_povf[LAT-1]) begin
            w_res_z = c_int_min;
            w_res_r = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    logic [N-1:0]    r_mz   [DEPTH];
    logic [N-1:0]    r_mr   [DEPTH];
    logic [TW-1:0]   r_mtag [DEPTH];
    logic            r_mdbz [DEPTH];
    logic            r_movf [DEPTH];
    logic [c_pw-1:0] r_wr;
    logic [c_pw-1:0] r_rd;
    logic            w_pop;
    logic            w_has;

    // Last popped entry, shown while the FIFO is empty.
    logic [N-1:0]    r_lz;
    logic [N-1:0]    r_lr;
    logic [TW-1:0]   r_ltag;
    logic            r_ldbz;
    logic            r_lovf;

    assign w_has = (r_count != '0);
    assign w_pop = w_has & out_ready;

    always_ff @(posedge clock) begin
        if (w_emerge) begin
            r_mz[r_wr]   <= w_res_z;
            r_mr[r_wr]   <= w_res_r;
            r_mtag[r_wr] <= r_ptag[LAT-1];
            r_mdbz[r_wr] <= r_pdbz[LAT-1];
            r_movf[r_wr] <= r_povf[LAT-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inflight <= '0;
            r_count    <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_lz       <= '0;
            r_lr       <= '0;
            r_ltag     <= '0;
            r_ldbz     <= 1'b0;
            r_lovf     <= 1'b0;
        end else begin
            case ({w_accept, w_emerge})
                2'b10:   r_inflight <= r_inflight + c_iw'(1);
                2'b01:   r_inflight <= r_inflight - c_iw'(1);
                default: r_inflight <= r_inflight;
            endcase

            case ({w_emerge, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase

            if (w_emerge) begin
                r_wr <= (r_wr == c_ptr_last) ? '0 : r_wr + c_pw'(1);
            end

            if (w_pop) begin
                r_rd   <= (r_rd == c_ptr_last) ? '0 : r_rd + c_pw'(1);
                r_lz   <= r_mz[r_rd];
                r_lr   <= r_mr[r_rd];
                r_ltag <= r_mtag[r_rd];
                r_ldbz <= r_mdbz[r_rd];
                r_lovf <= r_movf[r_rd];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------------
    assign out_valid = w_has;
    assign out_z     = w_has ? r_mz[r_rd]   : r_lz;
    assign out_r     = w_has ? r_mr[r_rd]   : r_lr;
    assign out_tag   = w_has ? r_mtag[r_rd] : r_ltag;
    assign out_dbz   = w_has ? r_mdbz[r_rd] : r_ldbz;
    assign out_ovf   = w_has ? r_movf[r_rd] : r_lovf;

    assign busy = (r_inflight != '0) || w_has;

endmodule
`default_nettype wire
